// File: rtl/mux4_arb_pkg.sv
// mux4_arb_pkg: shared types and constants for the 4-way round-robin mux arbiter
package mux4_arb_pkg;
  localparam int NREQ = 4;
  localparam int IDX_W = 2;
  typedef enum logic [1:0] {IDLE, OWN, GAP} state_t;
  typedef logic [IDX_W-1:0] idx_t;
endpackage

// File: rtl/mux4_rr_arbiter_if.sv
// mux4_rr_arbiter_if: request/data bundle and grant/select/status outputs of the arbiter
interface mux4_rr_arbiter_if #(parameter int DATA_W = 1);
  import mux4_arb_pkg::*;
  logic [NREQ-1:0] REQ;
  logic DONE;
  logic [DATA_W-1:0] A, B, C, D, Z;
  logic [NREQ-1:0] GNT;
  logic S0, S1, BUSY, TIMEOUT;
  modport master (output REQ, DONE, A, B, C, D, input GNT, S0, S1, Z, BUSY, TIMEOUT);
  modport slave (input REQ, DONE, A, B, C, D, output GNT, S0, S1, Z, BUSY, TIMEOUT);
endinterface

// File: rtl/rr_pick4.sv
// rr_pick4: combinational round-robin pick, searching from ptr+1 upward with wraparound
module rr_pick4
  import mux4_arb_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  idx_t            ptr,
  output idx_t            idx,
  output logic            valid
);
  always_comb begin
    idx = ptr;
    valid = 1'b0;
    // walk from farthest to nearest so the nearest requester after ptr wins
    for (int i = NREQ; i >= 1; i--) begin
      if (req[idx_t'(ptr + idx_t'(i))]) begin
        idx = idx_t'(ptr + idx_t'(i));
        valid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin arbitrated 4:1 mux with IDLE/OWN/GAP grant FSM.
// Define MUX4_ARB_TIMEOUT_EN to build the MAX_HOLD hold counter and TIMEOUT pulse.
module mux4_rr_arbiter
  import mux4_arb_pkg::*;
#(
  parameter int DATA_W = 1,
  parameter int MAX_HOLD = 8
) (
  input logic CLK,
  input logic RST_N,
  mux4_rr_arbiter_if.slave bus
);
  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_hold
    $error("MAX_HOLD must be within 1..255");
  end
  state_t state, state_n;
  logic [NREQ-1:0] gnt, gnt_n;
  idx_t sel, sel_n, ptr, ptr_n, win;
  logic win_v, rel, tmo, to, to_n;
  logic [DATA_W-1:0] z_mux;
  rr_pick4 u_pick (.req(bus.REQ), .ptr(ptr), .idx(win), .valid(win_v));
`ifdef MUX4_ARB_TIMEOUT_EN
  logic [7:0] hold;
  assign tmo = hold >= 8'(MAX_HOLD);
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) hold <= '0;
    else if (state == IDLE && win_v) hold <= 8'd1;
    else if (state == OWN && !tmo) hold <= hold + 8'd1;
  end
`else
  assign tmo = 1'b0;
`endif
  // DONE takes precedence over a simultaneous hold-limit revocation
  assign rel = bus.DONE || !bus.REQ[sel];
  always_comb begin
    state_n = state;
    gnt_n = gnt;
    sel_n = sel;
    ptr_n = ptr;
    to_n = 1'b0;
    unique case (state)
      IDLE: if (win_v) begin
        state_n = OWN;
        gnt_n = NREQ'(1) << win;
        sel_n = win;
        ptr_n = win;
      end
      OWN: if (rel || tmo) begin
        state_n = GAP;
        gnt_n = '0;
        to_n = !rel;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
      gnt <= '0;
      sel <= '0;
      ptr <= idx_t'(NREQ - 1);
      to <= 1'b0;
    end else begin
      state <= state_n;
      gnt <= gnt_n;
      sel <= sel_n;
      ptr <= ptr_n;
      to <= to_n;
    end
  end
  assign z_mux = sel == 2'd0 ? bus.A : sel == 2'd1 ? bus.B : sel == 2'd2 ? bus.C : bus.D;
  assign bus.GNT = gnt;
  assign bus.S0 = sel[1];
  assign bus.S1 = sel[0];
  assign bus.BUSY = state == OWN;
  assign bus.TIMEOUT = to;
  assign bus.Z = bus.BUSY ? z_mux : '0;
endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb_mux4_rr_arbiter: directed scenarios plus random traffic checked against a behavioural model
module tb_mux4_rr_arbiter;
  localparam int DW = 8;
  localparam int MH = 4;
`ifdef MUX4_ARB_TIMEOUT_EN
  localparam bit TEN = 1'b1;
`else
  localparam bit TEN = 1'b0;
`endif
  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;
  mux4_rr_arbiter_if #(.DATA_W(DW)) bus ();
  mux4_rr_arbiter #(.DATA_W(DW), .MAX_HOLD(MH)) dut (.CLK(CLK), .RST_N(RST_N), .bus(bus));
  logic [DW-1:0] dat [4];
  assign bus.A = dat[0];
  assign bus.B = dat[1];
  assign bus.C = dat[2];
  assign bus.D = dat[3];
  int vectors = 0;
  int miscompares = 0;
  // model: phase 0 waiting, 1 granted to m_own, 2 one-cycle gap
  int m_st, m_own, m_ptr, m_hold;
  bit m_to;
  function automatic int rr_pick(logic [3:0] r, int p);
    for (int k = 1; k <= 4; k++) if (r[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction
  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      m_st = 0; m_own = 0; m_ptr = 3; m_hold = 0; m_to = 0;
    end else if (m_st == 0) begin
      m_to = 0;
      if (rr_pick(bus.REQ, m_ptr) >= 0) begin
        m_own = rr_pick(bus.REQ, m_ptr);
        m_ptr = m_own;
        m_hold = 1;
        m_st = 1;
      end
    end else if (m_st == 1) begin
      if (bus.DONE || !bus.REQ[m_own] || (TEN && m_hold >= MH)) begin
        m_to = !bus.DONE && bus.REQ[m_own];
        m_st = 2;
      end else begin
        m_to = 0;
        m_hold = m_hold < MH ? m_hold + 1 : MH;
      end
    end else begin
      m_st = 0; m_to = 0;
    end
  end
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(negedge CLK);
    check("gnt", 32'(bus.GNT), m_st == 1 ? 32'(1) << m_own : 32'd0);
    check("sel", 32'({bus.S0, bus.S1}), 32'(m_own));
    check("busy", 32'(bus.BUSY), 32'(m_st == 1));
    check("z", 32'(bus.Z), m_st == 1 ? 32'(dat[m_own]) : 32'd0);
    check("timeout", 32'(bus.TIMEOUT), 32'(m_to));
    check("onehot", 32'($countones(bus.GNT) <= 1), 32'd1);
  endtask
  task automatic do_reset();
    RST_N = 1'b0;
    bus.REQ = '0;
    bus.DONE = 1'b0;
    tick();
    check("rst_gnt", 32'(bus.GNT), 32'd0);
    check("rst_busy", 32'(bus.BUSY), 32'd0);
    RST_N = 1'b1;
  endtask
  initial begin
    int order [$];
    int exp_ord [5] = '{0, 1, 2, 3, 0};
    bit prev, found, ended, to_seen, regrant;
    int run, cnt, to_cnt;
    for (int i = 0; i < 4; i++) dat[i] = 8'($urandom);
    // first grant
    do_reset();
    bus.REQ = 4'b0001;
    tick();
    check("r030_gnt", 32'(bus.GNT), 32'd1);
    check("r030_sel", 32'({bus.S0, bus.S1}), 32'd0);
    check("r030_z", 32'(bus.Z), 32'(dat[0]));
    check("r030_busy", 32'(bus.BUSY), 32'd1);
    // rotation order with DONE every grant
    do_reset();
    bus.REQ = 4'b1111;
    bus.DONE = 1'b1;
    prev = 1'b0;
    for (int c = 0; c < 16; c++) begin
      tick();
      if (bus.GNT != 0 && !prev)
        for (int j = 0; j < 4; j++) if (bus.GNT[j]) order.push_back(j);
      prev = bus.GNT != 0;
    end
    check("r031_count", 32'(order.size() >= 5), 32'd1);
    for (int i = 0; i < 5 && i < order.size(); i++) check("r031_order", 32'(order[i]), 32'(exp_ord[i]));
    // owner drops request
    do_reset();
    bus.DONE = 1'b0;
    bus.REQ = 4'b0010;
    tick();
    tick();
    bus.REQ = 4'b1000;
    tick();
    check("r033_drop", 32'(bus.GNT), 32'd0);
    found = 1'b0;
    for (int c = 0; c < 4 && !found; c++) begin
      tick();
      found = bus.GNT == 4'b1000;
    end
    check("r033_regrant", 32'(found), 32'd1);
    check("r033_sel", 32'({bus.S0, bus.S1}), 32'd3);
    // asynchronous reset mid-grant
    do_reset();
    bus.REQ = 4'b0001;
    tick();
    #1 RST_N = 1'b0;
    #1;
    check("r034_async_gnt", 32'(bus.GNT), 32'd0);
    check("r034_async_busy", 32'(bus.BUSY), 32'd0);
    tick();
    RST_N = 1'b1;
    bus.REQ = 4'b1111;
    tick();
    check("r034_ptr", 32'(bus.GNT), 32'd1);
    // hold limit behaviour
    do_reset();
    bus.DONE = 1'b0;
    if (TEN) begin
      bus.REQ = 4'b0100;
      run = 0; ended = 0; to_seen = 0; regrant = 0;
      for (int c = 0; c < 12; c++) begin
        tick();
        if (bus.TIMEOUT) to_seen = 1;
        if (bus.GNT == 4'b0100 && !ended) run++;
        else if (bus.GNT == 0 && run > 0) ended = 1;
        if (ended && bus.GNT == 4'b0100) regrant = 1;
      end
      check("r032_hold", 32'(run), 32'(MH));
      check("r032_timeout", 32'(to_seen), 32'd1);
      check("r032_regrant", 32'(regrant), 32'd1);
    end else begin
      bus.REQ = 4'b0010;
      cnt = 0; to_cnt = 0;
      for (int c = 0; c < 300; c++) begin
        tick();
        if (bus.GNT == 4'b0010) cnt++;
        if (bus.TIMEOUT) to_cnt++;
      end
      check("r035_hold", 32'(cnt), 32'd300);
      check("r035_timeout", 32'(to_cnt), 32'd0);
    end
    // random traffic
    do_reset();
    for (int c = 0; c < 500; c++) begin
      if ($urandom_range(0, 3) == 0) bus.REQ = 4'($urandom_range(0, 15));
      bus.DONE = $urandom_range(0, 5) == 0;
      for (int i = 0; i < 4; i++) dat[i] = 8'($urandom);
      tick();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mux4_rr_arbiter.md
MUX4_RR_ARBITER -- requirements
Module: mux4_rr_arbiter

Interface
REQ-001 Parameter DATA_W, default 1, sets the width of data inputs A/B/C/D and output Z.
REQ-002 Parameter MAX_HOLD, default 8, sets the maximum number of consecutive cycles one grant may last (range 1..255).
REQ-003 Port CLK  input  1  single clock; all state updates on the rising edge.
REQ-004 Port RST_N  input  1  asynchronous, active-low reset.
REQ-005 Port REQ  input  4  request per requester; bit0=A, bit1=B, bit2=C, bit3=D.
REQ-006 Port DONE  input  1  current owner releases the resource this cycle.
REQ-007 Ports A, B, C, D  input  DATA_W  requester data.
REQ-008 Port GNT  output  4  one-hot grant, registered.
REQ-009 Ports S0, S1  output  1 each  registered mux selects; {S0,S1}=00 A, 01 B, 10 C, 11 D.
REQ-010 Port Z  output  DATA_W  data of the granted requester; 0 when no grant.
REQ-011 Port BUSY  output  1  high while a grant is active.
REQ-012 Port TIMEOUT  output  1  one-cycle pulse when a grant is revoked by MAX_HOLD.

Function
REQ-013 FSM SHALL have states IDLE, OWN and GAP.
REQ-014 IDLE: when REQ!=0, winner chosen round-robin starting at index (PTR+1) mod 4; next cycle state=OWN, GNT one-hot of winner, {S0,S1}=winner index, PTR=winner.
REQ-015 Grant latency SHALL be exactly one cycle from REQ sampled in IDLE to GNT high.
REQ-016 OWN -> GAP when DONE=1, or owner's REQ bit=0, or (macro enabled) hold count reaches MAX_HOLD; GNT clears on that edge.
REQ-017 DONE and timeout in the same cycle SHALL be treated as DONE (TIMEOUT stays 0).
REQ-018 REQ changes of non-owners during OWN SHALL be ignored.
REQ-019 GAP SHALL last exactly one cycle with GNT=0, BUSY=0, then go to IDLE.
REQ-020 S0/S1 SHALL hold their last value outside OWN; Z SHALL be 0 outside OWN.
REQ-021 Hold counter SHALL load 1 on entry to OWN and increment each OWN cycle, saturating at MAX_HOLD.
REQ-022 GNT SHALL never have more than one bit set.
REQ-023 Z SHALL be combinational from A/B/C/D via the registered selects, gated by BUSY.

Reset
REQ-024 With RST_N=0: state=IDLE, GNT=0, S0=S1=0, BUSY=0, TIMEOUT=0, hold counter=0, PTR=3 (A has first priority).
REQ-025 Reset asserted mid-OWN SHALL clear the grant immediately, without waiting for a clock edge.

Configuration
REQ-026 Macro MUX4_ARB_TIMEOUT_EN defined: MAX_HOLD limit enforced and TIMEOUT pulses on revocation.
REQ-027 Macro MUX4_ARB_TIMEOUT_EN undefined: no hold counter is built, a grant ends only on DONE or REQ drop, and TIMEOUT is tied 0.

Structure
REQ-028 Package mux4_arb_pkg SHALL hold the state enum (IDLE/OWN/GAP), IDX_W=2 and the NREQ=4 constant.
REQ-029 Sub-module rr_pick4 SHALL implement the combinational round-robin pick (inputs REQ and PTR; outputs winner index and valid).

Verification
REQ-030 Reset, then REQ=0001 -> next cycle GNT=0001, {S0,S1}=00, Z=A, BUSY=1.
REQ-031 REQ=1111 with DONE pulsed each grant -> grant order A, B, C, D, A with one GAP cycle between grants.
REQ-032 Macro on, MAX_HOLD=4, REQ=0100 held, DONE=0 -> GNT=0100 for 4 cycles, TIMEOUT pulse, then GAP, then re-grant to C.
REQ-033 Owner B drops REQ mid-grant while REQ[3]=1 -> GNT=0 next edge, GAP, then GNT=1000, {S0,S1}=11.
REQ-034 RST_N low asynchronously during OWN -> GNT=0 and BUSY=0 before the next CLK edge, and PTR=3 after release.
REQ-035 Macro off, REQ=0010 held 300 cycles with DONE=0 -> GNT stays 0010 and TIMEOUT stays 0.
